// File: rtl/writeback_arbiter.sv
// Register-file writeback arbiter: pipeline writeback has priority over a small
// FIFO of late LSU responses; also tracks pending load destinations and a last-write bypass.
module writeback_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_wb_valid,
  output logic        pipe_wb_ready,
  input  logic [4:0]  pipe_wb_rd,
  input  logic [31:0] pipe_wb_data,
  input  logic        lsu_wb_valid,
  output logic        lsu_wb_ready,
  input  logic [4:0]  lsu_wb_rd,
  input  logic [31:0] lsu_wb_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  output logic [31:0] pending,
  output logic        rf_en,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_data,
  output logic        byp_valid,
  output logic [4:0]  byp_rd,
  output logic [31:0] byp_data
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [SW-1:0] STARVE_MX = SW'(STARVE_LIMIT);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  wb_t           mem [DEPTH];
  wb_t           head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [SW-1:0] starve_cnt;
  logic          full, nonempty, starved, pipe_fire, pipe_wr, push, pop;
  logic          win_en;
  logic [4:0]    win_rd;
  logic [31:0]   win_data;
  logic [31:0]   pending_nxt;

  assign head          = mem[rd_ptr];
  assign full          = (count == FULL_CNT);
  assign nonempty      = (count != '0);
  assign starved       = nonempty && (starve_cnt == STARVE_MX);
  assign pipe_wb_ready = !starved;
  assign lsu_wb_ready  = !full;
  assign pipe_fire     = pipe_wb_valid && pipe_wb_ready;
  // A pipeline write to x0 does not use the port, so the FIFO may drain alongside it.
  assign pipe_wr       = pipe_fire && (pipe_wb_rd != 5'd0);
  assign pop           = nonempty && !pipe_wr;
  assign push          = lsu_wb_valid && (!full || pop);

  always_comb begin
    win_en   = 1'b0;
    win_rd   = pipe_wb_rd;
    win_data = pipe_wb_data;
    if (pipe_wr) begin
      win_en = 1'b1;
    end else if (pop && head.rd != 5'd0) begin
      win_en   = 1'b1;
      win_rd   = head.rd;
      win_data = head.data;
    end
  end

  // Set beats clear so a re-issued load to the same rd stays tracked.
  always_comb begin
    pending_nxt = pending;
    if (pop)         pending_nxt[head.rd]  = 1'b0;
    if (issue_valid) pending_nxt[issue_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{rd: lsu_wb_rd, data: lsu_wb_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      pending    <= '0;
      rf_en      <= 1'b0;
      rf_rd      <= '0;
      rf_data    <= '0;
      byp_valid  <= 1'b0;
      byp_rd     <= '0;
      byp_data   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (!nonempty || pop)           starve_cnt <= '0;
      else if (starve_cnt != STARVE_MX) starve_cnt <= starve_cnt + 1'b1;
      pending <= pending_nxt;
      rf_en   <= win_en;
      if (win_en) begin
        rf_rd     <= win_rd;
        rf_data   <= win_data;
        byp_valid <= 1'b1;
        byp_rd    <= win_rd;
        byp_data  <= win_data;
      end
    end
  end
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: priority, starvation, FIFO full, scoreboard, reset.
module tb_writeback_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_wb_valid, pipe_wb_ready;
  logic [4:0]  pipe_wb_rd;
  logic [31:0] pipe_wb_data;
  logic        lsu_wb_valid, lsu_wb_ready;
  logic [4:0]  lsu_wb_rd;
  logic [31:0] lsu_wb_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [31:0] pending;
  logic        rf_en;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;
  logic        byp_valid;
  logic [4:0]  byp_rd;
  logic [31:0] byp_data;

  int pass_cnt  = 0;
  int total_cnt = 0;

  writeback_arbiter #(.DEPTH(4), .STARVE_LIMIT(3)) dut (
    .clk(clk), .rst(rst),
    .pipe_wb_valid(pipe_wb_valid), .pipe_wb_ready(pipe_wb_ready),
    .pipe_wb_rd(pipe_wb_rd), .pipe_wb_data(pipe_wb_data),
    .lsu_wb_valid(lsu_wb_valid), .lsu_wb_ready(lsu_wb_ready),
    .lsu_wb_rd(lsu_wb_rd), .lsu_wb_data(lsu_wb_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .pending(pending),
    .rf_en(rf_en), .rf_rd(rf_rd), .rf_data(rf_data),
    .byp_valid(byp_valid), .byp_rd(byp_rd), .byp_data(byp_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pipe_wb_valid = 1'b0; pipe_wb_rd = '0; pipe_wb_data = '0;
    lsu_wb_valid  = 1'b0; lsu_wb_rd  = '0; lsu_wb_data  = '0;
    issue_valid   = 1'b0; issue_rd   = '0;
  endtask

  task automatic pipe(input logic [4:0] rd, input logic [31:0] d);
    pipe_wb_valid = 1'b1; pipe_wb_rd = rd; pipe_wb_data = d;
  endtask

  task automatic lsu(input logic [4:0] rd, input logic [31:0] d);
    lsu_wb_valid = 1'b1; lsu_wb_rd = rd; lsu_wb_data = d;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    #2;
    total_cnt++; if ({rf_en, rf_rd, rf_data} !== 38'd0) $display("FAIL reset_rf got %0b/%0d/%h want 0", rf_en, rf_rd, rf_data); else pass_cnt++;
    total_cnt++; if ({byp_valid, byp_rd, byp_data} !== 38'd0) $display("FAIL reset_byp got %0b/%0d/%h want 0", byp_valid, byp_rd, byp_data); else pass_cnt++;
    total_cnt++; if (pending !== 32'd0) $display("FAIL reset_pending got %h want 0", pending); else pass_cnt++;
    total_cnt++; if ({pipe_wb_ready, lsu_wb_ready} !== 2'b11) $display("FAIL reset_ready got %b want 11", {pipe_wb_ready, lsu_wb_ready}); else pass_cnt++;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_pipe_only();
    pipe(5'd5, 32'hDEADBEEF);
    #1;
    total_cnt++; if (pipe_wb_ready !== 1'b1) $display("FAIL pipe_ready got %b want 1", pipe_wb_ready); else pass_cnt++;
    tick(); idle();
    total_cnt++; if ({rf_en, rf_rd, rf_data} !== {1'b1, 5'd5, 32'hDEADBEEF}) $display("FAIL pipe_write got %b/%0d/%h want 1/5/deadbeef", rf_en, rf_rd, rf_data); else pass_cnt++;
    total_cnt++; if ({byp_valid, byp_rd, byp_data} !== {1'b1, 5'd5, 32'hDEADBEEF}) $display("FAIL pipe_byp got %b/%0d/%h want 1/5/deadbeef", byp_valid, byp_rd, byp_data); else pass_cnt++;
    pipe(5'd0, 32'h1234);
    tick(); idle();
    total_cnt++; if ({rf_en, rf_rd, rf_data} !== {1'b0, 5'd5, 32'hDEADBEEF}) $display("FAIL pipe_x0 got %b/%0d/%h want 0/5/deadbeef", rf_en, rf_rd, rf_data); else pass_cnt++;
    total_cnt++; if ({byp_rd, byp_data} !== {5'd5, 32'hDEADBEEF}) $display("FAIL pipe_x0_byp got %0d/%h want 5/deadbeef", byp_rd, byp_data); else pass_cnt++;
  endtask

  task automatic test_starve();
    lsu(5'd7, 32'h11);
    #1;
    total_cnt++; if (lsu_wb_ready !== 1'b1) $display("FAIL starve_lsu_ready got %b want 1", lsu_wb_ready); else pass_cnt++;
    tick(); idle();
    for (int i = 0; i < 3; i++) begin
      pipe(5'(10 + i), 32'h100 + i);
      #1;
      total_cnt++; if (pipe_wb_ready !== 1'b1) $display("FAIL starve_win%0d_ready got %b want 1", i, pipe_wb_ready); else pass_cnt++;
      tick();
      total_cnt++; if ({rf_en, rf_rd} !== {1'b1, 5'(10 + i)}) $display("FAIL starve_win%0d got %b/%0d want 1/%0d", i, rf_en, rf_rd, 10 + i); else pass_cnt++;
    end
    pipe(5'd20, 32'h200);
    #1;
    total_cnt++; if (pipe_wb_ready !== 1'b0) $display("FAIL starve_block got %b want 0", pipe_wb_ready); else pass_cnt++;
    tick();
    total_cnt++; if ({rf_en, rf_rd, rf_data} !== {1'b1, 5'd7, 32'h11}) $display("FAIL starve_pop got %b/%0d/%h want 1/7/11", rf_en, rf_rd, rf_data); else pass_cnt++;
    total_cnt++; if (pipe_wb_ready !== 1'b1) $display("FAIL starve_release got %b want 1", pipe_wb_ready); else pass_cnt++;
    tick(); idle();
    total_cnt++; if ({rf_en, rf_rd, rf_data} !== {1'b1, 5'd20, 32'h200}) $display("FAIL starve_after got %b/%0d/%h want 1/20/200", rf_en, rf_rd, rf_data); else pass_cnt++;
  endtask

  task automatic test_fifo_full();
    logic [4:0]  exp_rd [5];
    logic [31:0] exp_d  [5];
    exp_rd = '{5'd11, 5'd12, 5'd13, 5'd14, 5'd15};
    exp_d  = '{32'hA1, 32'hB2, 32'hC3, 32'hD4, 32'hE5};
    for (int i = 0; i < 4; i++) begin
      lsu(exp_rd[i], exp_d[i]);
      pipe(5'(24 + i), 32'h1000 + i);
      tick();
      total_cnt++; if ({rf_en, rf_rd} !== {1'b1, 5'(24 + i)}) $display("FAIL full_fill%0d got %b/%0d want 1/%0d", i, rf_en, rf_rd, 24 + i); else pass_cnt++;
    end
    lsu(exp_rd[4], exp_d[4]);
    pipe(5'd30, 32'h3000);
    #1;
    total_cnt++; if ({lsu_wb_ready, pipe_wb_ready} !== 2'b00) $display("FAIL full_ready got %b want 00", {lsu_wb_ready, pipe_wb_ready}); else pass_cnt++;
    tick(); idle();
    total_cnt++; if ({rf_en, rf_rd, rf_data} !== {1'b1, exp_rd[0], exp_d[0]}) $display("FAIL full_pop0 got %b/%0d/%h want 1/%0d/%h", rf_en, rf_rd, rf_data, exp_rd[0], exp_d[0]); else pass_cnt++;
    total_cnt++; if (lsu_wb_ready !== 1'b0) $display("FAIL full_still_full got %b want 0", lsu_wb_ready); else pass_cnt++;
    for (int i = 1; i < 5; i++) begin
      tick();
      total_cnt++; if ({rf_en, rf_rd, rf_data} !== {1'b1, exp_rd[i], exp_d[i]}) $display("FAIL full_pop%0d got %b/%0d/%h want 1/%0d/%h", i, rf_en, rf_rd, rf_data, exp_rd[i], exp_d[i]); else pass_cnt++;
    end
    tick();
    total_cnt++; if ({rf_en, lsu_wb_ready} !== 2'b01) $display("FAIL full_drained got %b want 01", {rf_en, lsu_wb_ready}); else pass_cnt++;
  endtask

  task automatic test_scoreboard();
    issue_valid = 1'b1; issue_rd = 5'd9;
    tick(); idle();
    total_cnt++; if (pending !== 32'h200) $display("FAIL sb_set got %h want 00000200", pending); else pass_cnt++;
    lsu(5'd9, 32'h99);
    tick(); idle();
    total_cnt++; if (pending !== 32'h200) $display("FAIL sb_queued got %h want 00000200", pending); else pass_cnt++;
    tick();
    total_cnt++; if ({rf_en, rf_rd, rf_data, pending} !== {1'b1, 5'd9, 32'h99, 32'h0}) $display("FAIL sb_clear got %b/%0d/%h pend %h want 1/9/99 pend 0", rf_en, rf_rd, rf_data, pending); else pass_cnt++;
    issue_valid = 1'b1; issue_rd = 5'd9;
    tick(); idle();
    lsu(5'd9, 32'h9A);
    tick(); idle();
    issue_valid = 1'b1; issue_rd = 5'd9;
    tick(); idle();
    total_cnt++; if ({rf_rd, rf_data, pending} !== {5'd9, 32'h9A, 32'h200}) $display("FAIL sb_set_wins got %0d/%h pend %h want 9/9a pend 00000200", rf_rd, rf_data, pending); else pass_cnt++;
    issue_valid = 1'b1; issue_rd = 5'd0;
    tick(); idle();
    total_cnt++; if (pending !== 32'h200) $display("FAIL sb_x0 got %h want 00000200", pending); else pass_cnt++;
  endtask

  task automatic test_zero_pop();
    lsu(5'd0, 32'h55);
    tick(); idle();
    lsu(5'd6, 32'h66);
    tick(); idle();
    total_cnt++; if ({rf_en, rf_rd, rf_data} !== {1'b0, 5'd9, 32'h9A}) $display("FAIL zero_pop got %b/%0d/%h want 0/9/9a", rf_en, rf_rd, rf_data); else pass_cnt++;
    tick();
    total_cnt++; if ({rf_en, rf_rd, rf_data} !== {1'b1, 5'd6, 32'h66}) $display("FAIL zero_next got %b/%0d/%h want 1/6/66", rf_en, rf_rd, rf_data); else pass_cnt++;
    total_cnt++; if ({byp_rd, byp_data} !== {5'd6, 32'h66}) $display("FAIL zero_byp got %0d/%h want 6/66", byp_rd, byp_data); else pass_cnt++;
  endtask

  task automatic test_reset_traffic();
    lsu(5'd21, 32'h21); pipe(5'd22, 32'h22);
    issue_valid = 1'b1; issue_rd = 5'd3;
    tick(); idle();
    lsu(5'd23, 32'h23); pipe(5'd24, 32'h24);
    tick(); idle();
    total_cnt++; if (pending !== 32'h208) $display("FAIL rt_pending_pre got %h want 00000208", pending); else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++; if ({rf_en, pending, byp_valid, lsu_wb_ready} !== {1'b0, 32'h0, 1'b0, 1'b1}) $display("FAIL rt_async got en %b pend %h byp %b lrdy %b want 0/0/0/1", rf_en, pending, byp_valid, lsu_wb_ready); else pass_cnt++;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++; if ({rf_en, byp_valid} !== 2'b00) $display("FAIL rt_stale%0d got en %b byp %b want 0/0", i, rf_en, byp_valid); else pass_cnt++;
    end
    total_cnt++; if ({pending, pipe_wb_ready, lsu_wb_ready} !== {32'h0, 2'b11}) $display("FAIL rt_after got pend %h rdy %b want 0/11", pending, {pipe_wb_ready, lsu_wb_ready}); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_pipe_only();
    test_starve();
    test_fifo_full();
    test_scoreboard();
    test_zero_pop();
    test_reset_traffic();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
